// File: rtl/apb_requester.sv
// APB requester: one command at a time, driven through SETUP/ACCESS with a one-cycle response pulse.
// Optional access-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_requester #(
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned MAX_DIM        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata,
    input  logic [MAX_DIM-1:0]    cmd_strb,
    output logic                  rsp_valid,
    output logic [BUS_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_err,
    output logic [15:0]           xfer_count,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [BUS_WIDTH-1:0]  pwdata,
    output logic [MAX_DIM-1:0]    pstrb,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [BUS_WIDTH-1:0]  prdata
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
    logic [MAX_DIM-1:0]    strb_q, strb_d;
    logic [BUS_WIDTH-1:0]  rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [15:0]           count_q, count_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WaitW-1:0] wait_q, wait_d;
`endif

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        count_d = count_q;
`ifdef APB_TIMEOUT_EN
        wait_d  = wait_q;
`endif
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d = StSetup;
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    strb_d  = cmd_write ? cmd_strb : '0;
                end
            end
            StSetup: begin
                state_d = StAccess;
`ifdef APB_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            StAccess: begin
                // pready wins over a timeout expiring in the same cycle
                if (pready) begin
                    state_d = StResp;
                    rdata_d = write_q ? '0 : prdata;
                    err_d   = pslverr;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
                count_d = count_q + 16'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
`ifdef APB_TIMEOUT_EN
            wait_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            count_q <= count_d;
`ifdef APB_TIMEOUT_EN
            wait_q  <= wait_d;
`endif
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign psel       = (state_q == StSetup) || (state_q == StAccess);
    assign penable    = (state_q == StAccess);
    assign rsp_valid  = (state_q == StResp);
    assign pwrite     = write_q;
    assign paddr      = addr_q;
    assign pwdata     = wdata_q;
    assign pstrb      = strb_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign xfer_count = count_q;

endmodule
